mest_pro_exec_seq: RTL and testbench
====================================

# mest_pro_exec_seq

Parametrised, fully synchronous execute unit for the MEST Pro core: takes one decoded instruction per `i_execute` pulse and produces registered results, flags, control pulses and register moves. Main-memory load and store run through a counted multi-cycle strobe FSM rather than fixed delays. The block sits between the decoder/PC logic and the main-memory and output-register interfaces.

## Interface
- `DATA_W`, 8: datapath width for operands, result, register A, memory data and output register.
- `ADDR_W`, 16: main-memory address width. The address is `{operand1, operand2}`, zero-extended or truncated to `ADDR_W`.
- `MEM_WAIT`, 4: number of cycles the memory strobe is held. Range 1..255.
- `clk` in 1: clock. All state changes on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_execute` in 1: start strobe. Sampled only in IDLE.
- `i_op_code` in 5: opcode.
- `i_operand1` in `DATA_W`: operand A, or address high byte.
- `i_operand2` in `DATA_W`: operand B, move destination, or address low byte.
- `i_load_reg` in `DATA_W`: load-register / memory read data.
- `o_busy` out 1: high while a memory access is in progress.
- `o_exec_done` out 1: one-cycle completion pulse.
- `o_result` out `DATA_W`: ALU result register.
- `o_carry`, `o_zero_flag` out 1: ALU flags.
- `o_jump`, `o_return_pc`, `o_output_enable` out 1: one-cycle pulses, coincident with `o_exec_done`.
- `o_end_of_code` out 1: sticky halt flag.
- `o_output`, `o_rega`, `o_mm_dat` out `DATA_W`: output register, register A, memory data register.
- `o_mm_addr` out `ADDR_W`: memory address.
- `o_mm_select`, `o_cs`, `o_we` out 1: memory strobes.

## Operation
- **Opcodes.**
  - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR.
  - 6 SR (op1>>1), 7 SL (op1<<1), 8 NEG (~op1).
  - 9 JMP, 10 RET.
  - 11 MVI, 12 MRA, 13 MLR, 14 MMDR, 15 MRR.
  - 16 OUTPUT, 17 STORE, 18 LOAD, 19 NOP, 20 HALT.
  - 21–31 execute as NOP.
- **States.**
  - IDLE: if `i_execute` is high and `o_end_of_code` is low, then memory ops go to MEM; all other ops complete in this same edge and stay in IDLE.
  - MEM: count `MEM_WAIT` cycles, then return to IDLE.
  - HALTED: entered when `o_end_of_code` is set. `i_execute` is ignored until reset.
- **ALU (ops 0–8).**
  - `o_result` is the low `DATA_W` bits of the result.
  - ADD: carry = carry-out. SUB: carry = borrow (op1 < op2). SL: carry = op1 MSB. SR: carry = op1 LSB. MUL: carry = OR of the upper `DATA_W` product bits. AND/OR/XOR/NEG: carry = 0.
  - zero = (`o_result` == 0).
  - Non-ALU ops hold `o_result` and both flags.
- **Moves (ops 11–15).**
  - Destination is `operand2`: 0 = output register, 1 = register A, 2 = memory data.
  - Sources: MVI → `operand1`; MRA → `o_rega`; MLR → `i_load_reg`; MMDR → `o_mm_dat`; MRR → `o_result`.
  - Illegal combinations (MRA→A, MMDR→MM, destination > 2) change nothing but still pulse done.
- **OUTPUT, JMP, RET.** Pulse the matching output for one cycle; no other state changes.
- **STORE / LOAD.**
  - On entry, latch `o_mm_addr`.
  - Hold `o_mm_select` = `o_cs` = 1 for exactly `MEM_WAIT` cycles; `o_we` = 1 during this window for STORE only. `o_mm_dat` drives the write data.
  - LOAD captures `i_load_reg` into `o_mm_dat` on the last strobe cycle.
- **HALT.** Sets `o_end_of_code`; it stays set until reset.

## Timing
- **Reset values.** All outputs 0, including flags, registers, `o_mm_addr` and strobes. State = IDLE, counter = 0.
- **Reset mid-MEM.** Strobes drop asynchronously, no done pulse is produced, and the state returns to IDLE.
- **Non-memory ops.** `i_execute` is sampled at edge N. Registers update at edge N, and `o_exec_done` (plus any pulse) is high during cycle N→N+1. Latency is 1. Back-to-back `i_execute` gives one op per cycle.
- **Memory ops.**
  - `i_execute` is sampled at edge N.
  - `o_busy`, `o_mm_select`, `o_cs` and `o_we` (STORE) are high from edge N to edge N+`MEM_WAIT`.
  - `o_exec_done` is high in the cycle after edge N+`MEM_WAIT`, with `o_busy` = 0.
  - Latency is `MEM_WAIT`+1.
- **Ignored requests.** `i_execute` while busy or halted is dropped, not queued.
- **Counter.** The counter never wraps. `MEM_WAIT` = 1 gives a single-cycle strobe.

## Test plan
- Reset, then ADD 0xFF+0x01 → `o_result` = 0x00, carry = 1, zero = 1, `o_exec_done` pulse 1 cycle later.
- SUB 0x03−0x05 → 0xFE with carry = 1. Then MUL 0x10×0x10 → 0x00 with carry = 1. Then NOP → flags unchanged.
- MVI 0x5A→A, MRA→output, MRR→MM → `o_rega` = 0x5A, `o_output` = 0x5A, `o_mm_dat` = prior result. MRA→A leaves everything unchanged and still pulses done.
- STORE op1 = 0x12, op2 = 0x34, `MEM_WAIT` = 4 → `o_mm_addr` = 0x1234, `o_we`/`o_mm_select` high exactly 4 cycles, done on cycle 5. `i_execute` asserted mid-access is ignored.
- LOAD with `i_load_reg` = 0xC3 → `o_mm_dat` = 0xC3, `o_we` never high. Reset asserted on strobe cycle 2 → all outputs 0 immediately, no done pulse.
- HALT → `o_end_of_code` = 1 and stays high. A subsequent ADD produces no done pulse and no result change until reset.

Source files
------------

// File: rtl/mest_pro_exec_seq.sv
// MEST Pro execute unit: single-cycle ALU/move/control ops, counted-strobe
// main-memory load/store, and a sticky halt.
module mest_pro_exec_seq #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int MEM_WAIT = 4
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_execute,
  input  logic [4:0]        i_op_code,
  input  logic [DATA_W-1:0] i_operand1,
  input  logic [DATA_W-1:0] i_operand2,
  input  logic [DATA_W-1:0] i_load_reg,
  output logic              o_busy,
  output logic              o_exec_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero_flag,
  output logic              o_jump,
  output logic              o_return_pc,
  output logic              o_output_enable,
  output logic              o_end_of_code,
  output logic [DATA_W-1:0] o_output,
  output logic [DATA_W-1:0] o_rega,
  output logic [DATA_W-1:0] o_mm_dat,
  output logic [ADDR_W-1:0] o_mm_addr,
  output logic              o_mm_select,
  output logic              o_cs,
  output logic              o_we
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_HALTED
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_MUL    = 5'd2,
    OP_AND    = 5'd3,
    OP_OR     = 5'd4,
    OP_XOR    = 5'd5,
    OP_SR     = 5'd6,
    OP_SL     = 5'd7,
    OP_NEG    = 5'd8,
    OP_JMP    = 5'd9,
    OP_RET    = 5'd10,
    OP_MVI    = 5'd11,
    OP_MRA    = 5'd12,
    OP_MLR    = 5'd13,
    OP_MMDR   = 5'd14,
    OP_MRR    = 5'd15,
    OP_OUTPUT = 5'd16,
    OP_STORE  = 5'd17,
    OP_LOAD   = 5'd18,
    OP_NOP    = 5'd19,
    OP_HALT   = 5'd20
  } op_e;

  localparam logic [7:0] LP_WAIT = 8'(MEM_WAIT);

  state_e r_state;
  state_e w_state_nxt;

  logic [7:0]          r_cnt;
  logic                r_is_store;
  logic                r_done;
  logic                r_jump;
  logic                r_ret;
  logic                r_oe;
  logic                r_eoc;
  logic [DATA_W-1:0]   r_result;
  logic                r_carry;
  logic                r_zero;
  logic [DATA_W-1:0]   r_output;
  logic [DATA_W-1:0]   r_rega;
  logic [DATA_W-1:0]   r_mm_dat;
  logic [ADDR_W-1:0]   r_mm_addr;

  logic                w_start;
  logic                w_mem_done;
  logic                w_is_mem;
  logic                w_is_alu;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_c;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_is_move;
  logic                w_mv_ok;
  logic [DATA_W-1:0]   w_mv_src;
  logic                w_dst_out;
  logic                w_dst_a;
  logic                w_dst_mm;

  assign w_is_mem   = (i_op_code == OP_STORE) || (i_op_code == OP_LOAD);
  assign w_start    = (r_state == ST_IDLE) && i_execute && !r_eoc;
  assign w_mem_done = (r_state == ST_MEM) && (r_cnt == LP_WAIT);

  assign w_sum  = {1'b0, i_operand1} + {1'b0, i_operand2};
  assign w_diff = i_operand1 - i_operand2;
  assign w_prod = {{DATA_W{1'b0}}, i_operand1} * {{DATA_W{1'b0}}, i_operand2};

  always_comb begin
    w_is_alu  = 1'b1;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (i_op_code)
      OP_ADD: begin
        w_alu_res = w_sum[DATA_W-1:0];
        w_alu_c   = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_c   = (i_operand1 < i_operand2);
      end
      OP_MUL: begin
        w_alu_res = w_prod[DATA_W-1:0];
        w_alu_c   = |w_prod[2*DATA_W-1:DATA_W];
      end
      OP_AND: w_alu_res = i_operand1 & i_operand2;
      OP_OR:  w_alu_res = i_operand1 | i_operand2;
      OP_XOR: w_alu_res = i_operand1 ^ i_operand2;
      OP_SR: begin
        w_alu_res = {1'b0, i_operand1[DATA_W-1:1]};
        w_alu_c   = i_operand1[0];
      end
      OP_SL: begin
        w_alu_res = {i_operand1[DATA_W-2:0], 1'b0};
        w_alu_c   = i_operand1[DATA_W-1];
      end
      OP_NEG:  w_alu_res = ~i_operand1;
      default: w_is_alu = 1'b0;
    endcase
  end

  assign w_dst_out = (i_operand2 == '0);
  assign w_dst_a   = (i_operand2 == DATA_W'(1));
  assign w_dst_mm  = (i_operand2 == DATA_W'(2));

  // A move is legal only to destinations 0..2 and never register-to-itself.
  always_comb begin
    w_is_move = 1'b1;
    w_mv_src  = '0;
    w_mv_ok   = w_dst_out || w_dst_a || w_dst_mm;
    case (i_op_code)
      OP_MVI:  w_mv_src = i_operand1;
      OP_MRA: begin
        w_mv_src = r_rega;
        if (w_dst_a) w_mv_ok = 1'b0;
      end
      OP_MLR:  w_mv_src = i_load_reg;
      OP_MMDR: begin
        w_mv_src = r_mm_dat;
        if (w_dst_mm) w_mv_ok = 1'b0;
      end
      OP_MRR:  w_mv_src = r_result;
      default: begin
        w_is_move = 1'b0;
        w_mv_ok   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_is_mem)                    w_state_nxt = ST_MEM;
          else if (i_op_code == OP_HALT)   w_state_nxt = ST_HALTED;
        end
      end
      ST_MEM:    if (w_mem_done) w_state_nxt = ST_IDLE;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_done     <= 1'b0;
      r_jump     <= 1'b0;
      r_ret      <= 1'b0;
      r_oe       <= 1'b0;
      r_eoc      <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_output   <= '0;
      r_rega     <= '0;
      r_mm_dat   <= '0;
      r_mm_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      r_jump <= 1'b0;
      r_ret  <= 1'b0;
      r_oe   <= 1'b0;
      if (w_start) begin
        if (w_is_mem) begin
          r_mm_addr  <= ADDR_W'({i_operand1, i_operand2});
          r_is_store <= (i_op_code == OP_STORE);
          r_cnt      <= 8'd1;
        end else begin
          r_done <= 1'b1;
          if (w_is_alu) begin
            r_result <= w_alu_res;
            r_carry  <= w_alu_c;
            r_zero   <= (w_alu_res == '0);
          end
          if (w_is_move && w_mv_ok) begin
            if (w_dst_out) r_output <= w_mv_src;
            if (w_dst_a)   r_rega   <= w_mv_src;
            if (w_dst_mm)  r_mm_dat <= w_mv_src;
          end
          if (i_op_code == OP_JMP)    r_jump <= 1'b1;
          if (i_op_code == OP_RET)    r_ret  <= 1'b1;
          if (i_op_code == OP_OUTPUT) r_oe   <= 1'b1;
          if (i_op_code == OP_HALT)   r_eoc  <= 1'b1;
        end
      end else if (r_state == ST_MEM) begin
        if (w_mem_done) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          if (!r_is_store) r_mm_dat <= i_load_reg;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  // Strobes decode the state register so reset drops them immediately.
  assign o_busy          = (r_state == ST_MEM);
  assign o_mm_select     = o_busy;
  assign o_cs            = o_busy;
  assign o_we            = o_busy && r_is_store;
  assign o_exec_done     = r_done;
  assign o_result        = r_result;
  assign o_carry         = r_carry;
  assign o_zero_flag     = r_zero;
  assign o_jump          = r_jump;
  assign o_return_pc     = r_ret;
  assign o_output_enable = r_oe;
  assign o_end_of_code   = r_eoc;
  assign o_output        = r_output;
  assign o_rega          = r_rega;
  assign o_mm_dat        = r_mm_dat;
  assign o_mm_addr       = r_mm_addr;

endmodule

// File: tb/tb_mest_pro_exec_seq.sv
// Directed bench for mest_pro_exec_seq: vector table for single-cycle ops,
// hand-written sequences for memory strobes, reset mid-access and halt.
module tb_mest_pro_exec_seq;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_execute;
  logic [4:0] i_op_code;
  logic [7:0] i_operand1, i_operand2, i_load_reg;
  logic       o_busy, o_exec_done, o_carry, o_zero_flag;
  logic       o_jump, o_return_pc, o_output_enable, o_end_of_code;
  logic [7:0] o_result, o_output, o_rega, o_mm_dat;
  logic [15:0] o_mm_addr;
  logic       o_mm_select, o_cs, o_we;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mest_pro_exec_seq #(.DATA_W(8), .ADDR_W(16), .MEM_WAIT(4)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_execute(i_execute), .i_op_code(i_op_code),
    .i_operand1(i_operand1), .i_operand2(i_operand2), .i_load_reg(i_load_reg),
    .o_busy(o_busy), .o_exec_done(o_exec_done), .o_result(o_result),
    .o_carry(o_carry), .o_zero_flag(o_zero_flag), .o_jump(o_jump),
    .o_return_pc(o_return_pc), .o_output_enable(o_output_enable),
    .o_end_of_code(o_end_of_code), .o_output(o_output), .o_rega(o_rega),
    .o_mm_dat(o_mm_dat), .o_mm_addr(o_mm_addr), .o_mm_select(o_mm_select),
    .o_cs(o_cs), .o_we(o_we)
  );

  logic [58:0] all_o;
  assign all_o = {o_busy, o_exec_done, o_result, o_carry, o_zero_flag, o_jump,
                  o_return_pc, o_output_enable, o_end_of_code, o_output, o_rega,
                  o_mm_dat, o_mm_addr, o_mm_select, o_cs, o_we};

  // {result, carry, zero, output, rega, mm_dat, done, jump, ret, oe, busy}
  logic [38:0] vec_o;
  assign vec_o = {o_result, o_carry, o_zero_flag, o_output, o_rega, o_mm_dat,
                  o_exec_done, o_jump, o_return_pc, o_output_enable, o_busy};

  typedef struct {
    logic [4:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  ld;
    logic [38:0] exp;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] ld, input logic [7:0] res, input logic c,
                              input logic z, input logic [7:0] out, input logic [7:0] ra,
                              input logic [7:0] mm, input logic j, input logic r, input logic oe);
    vec_t v;
    v.op  = op;
    v.a   = a;
    v.b   = b;
    v.ld  = ld;
    v.exp = {res, c, z, out, ra, mm, 1'b1, j, r, oe, 1'b0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ex, input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ld);
    i_execute  = ex;
    i_op_code  = op;
    i_operand1 = a;
    i_operand2 = b;
    i_load_reg = ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory op with an ignored execute attempt during the strobe window.
  task automatic run_mem(input string nm, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ld, input logic is_st);
    logic s;
    drive(1'b1, op, a, b, ld);
    tick();
    for (int k = 0; k < 6; k++) begin
      s = (k < 4);
      chk($sformatf("%s_k%0d", nm, k), {59'd0, o_busy, o_mm_select, o_cs, o_we, o_exec_done},
          {59'd0, s, s, s, s & is_st, (k == 4)});
      if (k == 0) drive(1'b1, 5'd0, 8'hAB, 8'hCD, ld);
      if (k == 2) drive(1'b0, 5'd19, 8'h00, 8'h00, ld);
      tick();
    end
  endtask

  initial begin
    tbl[0]  = mk(5'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(5'd1,  8'h03, 8'h05, 8'h00, 8'hFE, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[2]  = mk(5'd2,  8'h10, 8'h10, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[3]  = mk(5'd19, 8'h12, 8'h34, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[4]  = mk(5'd11, 8'h5A, 8'h01, 8'h00, 8'h00, 1, 1, 8'h00, 8'h5A, 8'h00, 0, 0, 0);
    tbl[5]  = mk(5'd12, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'h5A, 8'h00, 0, 0, 0);
    tbl[6]  = mk(5'd0,  8'h20, 8'h13, 8'h00, 8'h33, 0, 0, 8'h5A, 8'h5A, 8'h00, 0, 0, 0);
    tbl[7]  = mk(5'd15, 8'h00, 8'h02, 8'h00, 8'h33, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[8]  = mk(5'd12, 8'h00, 8'h01, 8'h00, 8'h33, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[9]  = mk(5'd5,  8'hA5, 8'h0F, 8'h00, 8'hAA, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[10] = mk(5'd6,  8'h03, 8'h00, 8'h00, 8'h01, 1, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[11] = mk(5'd7,  8'h81, 8'h00, 8'h00, 8'h02, 1, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[12] = mk(5'd8,  8'h0F, 8'h00, 8'h00, 8'hF0, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[13] = mk(5'd3,  8'hF0, 8'h3C, 8'h00, 8'h30, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[14] = mk(5'd4,  8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[15] = mk(5'd1,  8'h05, 8'h03, 8'h00, 8'h02, 0, 0, 8'h5A, 8'h5A, 8'h33, 0, 0, 0);
    tbl[16] = mk(5'd13, 8'h00, 8'h00, 8'h77, 8'h02, 0, 0, 8'h77, 8'h5A, 8'h33, 0, 0, 0);
    tbl[17] = mk(5'd14, 8'h00, 8'h01, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 0, 0);
    tbl[18] = mk(5'd9,  8'h11, 8'h22, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 1, 0, 0);
    tbl[19] = mk(5'd10, 8'h11, 8'h22, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 1, 0);
    tbl[20] = mk(5'd16, 8'h11, 8'h22, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 0, 1);
    tbl[21] = mk(5'd11, 8'h99, 8'h03, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 0, 0);
    tbl[22] = mk(5'd25, 8'hFF, 8'hFF, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 0, 0);
    tbl[23] = mk(5'd14, 8'h00, 8'h02, 8'h00, 8'h02, 0, 0, 8'h77, 8'h33, 8'h33, 0, 0, 0);

    i_reset_n = 1'b0;
    drive(1'b0, 5'd19, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {5'd0, all_o}, 64'd0);
    i_reset_n = 1'b1;
    tick();

    // Back-to-back single-cycle ops, one per clock.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ld);
      tick();
      chk($sformatf("vec%0d", i), {25'd0, vec_o}, {25'd0, tbl[i].exp});
    end
    drive(1'b0, 5'd19, 8'h00, 8'h00, 8'h00);
    tick();
    chk("idle_no_done", {62'd0, o_exec_done, o_busy}, 64'd0);

    run_mem("store", 5'd17, 8'h12, 8'h34, 8'h00, 1'b1);
    chk("store_addr", {48'd0, o_mm_addr}, {48'd0, 16'h1234});
    chk("store_keep", {40'd0, o_result, o_mm_dat, o_rega}, {40'd0, 8'h02, 8'h33, 8'h33});

    run_mem("load", 5'd18, 8'h00, 8'h56, 8'hC3, 1'b0);
    chk("load_dat", {56'd0, o_mm_dat}, {56'd0, 8'hC3});
    chk("load_addr", {48'd0, o_mm_addr}, {48'd0, 16'h0056});
    chk("load_keep", {56'd0, o_result}, {56'd0, 8'h02});

    // Reset asserted during the second strobe cycle.
    drive(1'b1, 5'd18, 8'h77, 8'h88, 8'h5E);
    tick();
    drive(1'b0, 5'd19, 8'h00, 8'h00, 8'h5E);
    chk("rst_mid_pre", {61'd0, o_busy, o_cs, o_we}, {61'd0, 3'b110});
    @(posedge clk);
    #2 i_reset_n = 1'b0;
    #1 chk("rst_mid_async", {5'd0, all_o}, 64'd0);
    tick();
    i_reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rst_mid_quiet%0d", k), {5'd0, all_o}, 64'd0);
    end

    drive(1'b1, 5'd0, 8'h01, 8'h01, 8'h00);
    tick();
    chk("pre_halt_add", {55'd0, o_exec_done, o_result}, {55'd0, 1'b1, 8'h02});
    drive(1'b1, 5'd20, 8'h00, 8'h00, 8'h00);
    tick();
    chk("halt", {62'd0, o_exec_done, o_end_of_code}, {62'd0, 2'b11});
    drive(1'b1, 5'd0, 8'h05, 8'h05, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("halted%0d", k), {54'd0, o_exec_done, o_end_of_code, o_busy, o_result},
          {54'd0, 1'b0, 1'b1, 1'b0, 8'h02});
    end
    drive(1'b0, 5'd19, 8'h00, 8'h00, 8'h00);
    i_reset_n = 1'b0;
    #1 chk("halt_reset", {5'd0, all_o}, 64'd0);
    tick();
    i_reset_n = 1'b1;
    drive(1'b1, 5'd0, 8'h05, 8'h05, 8'h00);
    tick();
    chk("post_halt_add", {54'd0, o_exec_done, o_end_of_code, o_carry, o_result},
        {54'd0, 1'b1, 1'b0, 1'b0, 8'h0A});
    drive(1'b0, 5'd19, 8'h00, 8'h00, 8'h00);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
